// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: round sequencer, rate-limited move pulses, lives and score for the frog game
module frog_game_ctrl #(
    parameter int LIVES      = 3,
    parameter int GOAL_X     = 14,
    parameter int HIT_CYCLES = 4,
    parameter int WIN_CYCLES = 4,
    parameter int HOLDOFF    = 2,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         player_input,
    input  logic [3:0]         frog_x,
    input  logic               car_hit,
    output logic               new_game,
    output logic               gameover,
    output logic [3:0]         move_cmd,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_HIT   = 3'd3;
    localparam logic [2:0] S_WIN   = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;
    localparam int CW = $clog2((HIT_CYCLES > WIN_CYCLES ? HIT_CYCLES : WIN_CYCLES) + 1);
    localparam int HW = $clog2(HOLDOFF + 2);

    logic [2:0]    r_state;
    logic          r_start_prev;
    logic [3:0]    r_btn_prev;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hold;
    logic          w_start_edge;
    logic [3:0]    w_btn_edge;
    logic [3:0]    w_pick;

    assign state_o = r_state;

    // Rising edges of the buttons and the single highest-priority move (up > down > left > right)
    always_comb begin
        w_start_edge = start & ~r_start_prev;
        w_btn_edge   = player_input & ~r_btn_prev;
        w_pick       = w_btn_edge[3] ? 4'b1000 :
                       w_btn_edge[2] ? 4'b0100 :
                       w_btn_edge[1] ? 4'b0010 :
                       w_btn_edge[0] ? 4'b0001 : 4'b0000;
    end

    // Round state machine; every output is registered and set on the edge that enters its state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_start_prev <= 1'b1;
            r_btn_prev   <= 4'hf;
            r_cnt        <= '0;
            r_hold       <= '0;
            new_game     <= 1'b0;
            gameover     <= 1'b1;
            move_cmd     <= 4'b0;
            lives        <= 3'd0;
            score        <= '0;
        end else begin
            r_start_prev <= start;
            r_btn_prev   <= player_input;
            new_game     <= 1'b0;
            move_cmd     <= 4'b0;
            if (r_state == S_PLAY && r_hold != '0)
                r_hold <= r_hold - 1'b1;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (w_start_edge) begin
                        r_state  <= S_START;
                        new_game <= 1'b1;
                        lives    <= LIVES[2:0];
                        score    <= '0;
                        gameover <= 1'b0;
                        r_hold   <= '0;
                    end
                end
                S_START: r_state <= S_PLAY;
                S_PLAY: begin
                    if (car_hit) begin
                        r_state  <= S_HIT;
                        gameover <= 1'b1;
                        lives    <= (lives == 3'd0) ? 3'd0 : lives - 1'b1;
                        r_cnt    <= CW'(HIT_CYCLES - 1);
                    end else if (frog_x == GOAL_X[3:0]) begin
                        r_state  <= S_WIN;
                        gameover <= 1'b1;
                        score    <= (&score) ? score : score + 1'b1;
                        r_cnt    <= CW'(WIN_CYCLES - 1);
                    end else if (r_hold == '0 && w_pick != 4'b0) begin
                        move_cmd <= w_pick;
                        r_hold   <= HW'(HOLDOFF);
                    end
                end
                S_HIT, S_WIN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_state == S_HIT && lives == 3'd0) begin
                        r_state <= S_OVER;
                    end else begin
                        r_state  <= S_PLAY;
                        new_game <= 1'b1;
                        gameover <= 1'b0;
                        r_hold   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
